// File: rtl/paam_data_tx.sv
`default_nettype none
// ============================================================================
// Module      : paam_data_tx
// Description : Buffers upstream payload words in a small FIFO and plays them
//               out to the PAAM data bus as fixed-length frames separated by
//               idle gaps. Flags the first word of each frame on a one-hot
//               per-panel strobe and keeps frame / drop / underrun status.
// Revision    : 1.0 - initial release
// ============================================================================
module paam_data_tx #(
    parameter int FIFO_DEPTH = 16,  // power of two, >= 4
    parameter int FRAME_LEN  = 8,   // 1..255 words per frame
    parameter int GAP_LEN    = 2    // 1..15 idle cycles between frames
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [9:0]  s_data,
    input  logic        s_sof,
    input  logic [1:0]  s_panel,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [9:0]  paam_data,
    output logic [3:0]  paam_symbol_start,
    output logic        paam_data_valid,
    output logic [15:0] frame_cnt,
    output logic [7:0]  drop_cnt,
    output logic        underrun_err
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [AW:0]   c_depth    = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   c_fill_one = (AW+1)'(1);
    localparam logic [AW-1:0] c_ptr_one  = AW'(1);
    localparam logic [7:0]    c_last_idx = 8'(FRAME_LEN - 1);
    localparam logic [3:0]    c_gap_last = 4'(GAP_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping. Each entry is {sof, panel, data}.
    // ------------------------------------------------------------------
    logic [12:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   fill_q,   fill_d;

    logic          wr_en;
    logic          pop;
    logic          fifo_empty;
    logic [12:0]   head;
    logic          head_sof;
    logic [1:0]    head_panel;
    logic [9:0]    head_data;

    // ------------------------------------------------------------------
    // Frame sequencer and output registers
    // ------------------------------------------------------------------
    state_t        state_q,     state_d;
    logic [7:0]    word_idx_q,  word_idx_d;   // words of this frame already popped
    logic [3:0]    gap_q,       gap_d;        // remaining gap cycles minus one
    logic [9:0]    data_q,      data_d;
    logic [3:0]    sym_q,       sym_d;
    logic          valid_q,     valid_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic [7:0]    drop_cnt_q,  drop_cnt_d;
    logic          underrun_q,  underrun_d;

    // Ready is derived from the registered fill so it never depends on this
    // cycle's pop; a freed slot becomes visible one cycle after the pop.
    assign s_ready    = (fill_q < c_depth);
    assign wr_en      = s_valid & s_ready;
    assign fifo_empty = (fill_q == '0);
    assign head       = fifo_mem[rd_ptr_q];
    assign head_sof   = head[12];
    assign head_panel = head[11:10];
    assign head_data  = head[9:0];

    // Store accepted words; storage needs no reset since fill gates reads.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            fifo_mem[wr_ptr_q] <= {s_sof, s_panel, s_data};
        end
    end

    // Pointer and fill-count update; simultaneous push and pop cancel out.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + c_ptr_one;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_one;
        end
        case ({wr_en, pop})
            2'b10:   fill_d = fill_q + c_fill_one;
            2'b01:   fill_d = fill_q - c_fill_one;
            default: fill_d = fill_q;
        endcase
    end

    // Next-state and output logic: hunt for sof, stream a frame, then gap.
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        word_idx_d  = word_idx_q;
        gap_d       = gap_q;
        data_d      = data_q;      // bus holds its last word when idle
        sym_d       = 4'b0000;
        valid_d     = 1'b0;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        underrun_d  = underrun_q;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (!head_sof) begin
                        // Not aligned to a frame start: throw the word away.
                        pop = 1'b1;
                        if (drop_cnt_q != 8'hFF) begin
                            drop_cnt_d = drop_cnt_q + 8'd1;
                        end
                    end else if (enable) begin
                        // Word 0 of a new frame; its panel selects the strobe.
                        pop     = 1'b1;
                        valid_d = 1'b1;
                        data_d  = head_data;
                        sym_d   = 4'b0001 << head_panel;
                        if (c_last_idx == 8'd0) begin
                            frame_cnt_d = frame_cnt_q + 16'd1;
                            gap_d       = c_gap_last;
                            state_d     = ST_GAP;
                        end else begin
                            word_idx_d = 8'd1;
                            state_d    = ST_SEND;
                        end
                    end
                end
            end

            ST_SEND: begin
                if (fifo_empty) begin
                    // Upstream starved mid-frame: abandon it, leave count alone.
                    underrun_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    // sof on a later word is ignored and sent as plain data.
                    pop     = 1'b1;
                    valid_d = 1'b1;
                    data_d  = head_data;
                    if (word_idx_q == c_last_idx) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        gap_d       = c_gap_last;
                        state_d     = ST_GAP;
                    end else begin
                        word_idx_d = word_idx_q + 8'd1;
                    end
                end
            end

            ST_GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            state_q     <= ST_IDLE;
            word_idx_q  <= 8'd0;
            gap_q       <= 4'd0;
            data_q      <= 10'd0;
            sym_q       <= 4'd0;
            valid_q     <= 1'b0;
            frame_cnt_q <= 16'd0;
            drop_cnt_q  <= 8'd0;
            underrun_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            state_q     <= state_d;
            word_idx_q  <= word_idx_d;
            gap_q       <= gap_d;
            data_q      <= data_d;
            sym_q       <= sym_d;
            valid_q     <= valid_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            underrun_q  <= underrun_d;
        end
    end

    assign paam_data         = data_q;
    assign paam_symbol_start = sym_q;
    assign paam_data_valid   = valid_q;
    assign frame_cnt         = frame_cnt_q;
    assign drop_cnt          = drop_cnt_q;
    assign underrun_err      = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_paam_data_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_paam_data_tx
// Description : Self-checking bench for paam_data_tx: directed vector table,
//               hand-written corner sequences and random traffic compared
//               against a queue-based frame model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_paam_data_tx;

    localparam int DEPTH = 16;
    localparam int FLEN  = 8;
    localparam int GLEN  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [9:0]  s_data;
    logic        s_sof;
    logic [1:0]  s_panel;
    logic        s_valid;
    logic        s_ready;
    logic [9:0]  paam_data;
    logic [3:0]  paam_symbol_start;
    logic        paam_data_valid;
    logic [15:0] frame_cnt;
    logic [7:0]  drop_cnt;
    logic        underrun_err;

    paam_data_tx #(
        .FIFO_DEPTH (DEPTH),
        .FRAME_LEN  (FLEN),
        .GAP_LEN    (GLEN)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .enable            (enable),
        .s_data            (s_data),
        .s_sof             (s_sof),
        .s_panel           (s_panel),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .paam_data         (paam_data),
        .paam_symbol_start (paam_symbol_start),
        .paam_data_valid   (paam_data_valid),
        .frame_cnt         (frame_cnt),
        .drop_cnt          (drop_cnt),
        .underrun_err      (underrun_err)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int bad    = 0;
    int cyc    = 0;
    int vcount = 0;
    int vlog[$];

    // Reference model: the FIFO is a queue, the frame progress is a count of
    // words still owed and gap cycles still owed.
    logic [12:0] mq[$];
    int          m_words_left = 0;
    int          m_gap_left   = 0;
    logic        m_ready      = 1'b1;
    logic        m_valid      = 1'b0;
    logic [9:0]  m_data       = 10'd0;
    logic [3:0]  m_sym        = 4'd0;
    logic [15:0] m_frame      = 16'd0;
    logic [7:0]  m_drop       = 8'd0;
    logic        m_underrun   = 1'b0;

    typedef struct {
        logic       v;
        logic       sof;
        logic [9:0] data;
        logic       ev;
        logic [9:0] ed;
        logic [3:0] es;
        logic [15:0] ef;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Advance the model by one clock given the inputs presented before the edge.
    task automatic model_step(input logic r, input logic e, input logic v, input logic sf,
                              input logic [1:0] pn, input logic [9:0] dt);
        logic        accept;
        logic        emit;
        logic        first;
        logic [12:0] w;
        if (r) begin
            mq.delete();
            m_words_left = 0;
            m_gap_left   = 0;
            m_valid      = 1'b0;
            m_data       = 10'd0;
            m_sym        = 4'd0;
            m_frame      = 16'd0;
            m_drop       = 8'd0;
            m_underrun   = 1'b0;
            m_ready      = 1'b1;
            return;
        end
        accept = v && (mq.size() < DEPTH);
        emit   = 1'b0;
        first  = 1'b0;
        w      = 13'd0;
        if (m_words_left > 0) begin
            if (mq.size() == 0) begin
                m_underrun   = 1'b1;
                m_words_left = 0;
            end else begin
                w = mq.pop_front();
                emit = 1'b1;
                m_words_left--;
                if (m_words_left == 0) begin
                    m_frame++;
                    m_gap_left = GLEN;
                end
            end
        end else if (m_gap_left > 0) begin
            m_gap_left--;
        end else if (mq.size() > 0) begin
            if (!mq[0][12]) begin
                void'(mq.pop_front());
                if (m_drop != 8'd255) m_drop++;
            end else if (e) begin
                w = mq.pop_front();
                emit  = 1'b1;
                first = 1'b1;
                m_words_left = FLEN - 1;
                if (m_words_left == 0) begin
                    m_frame++;
                    m_gap_left = GLEN;
                end
            end
        end
        if (accept) mq.push_back({sf, pn, dt});
        m_valid = emit;
        if (emit) m_data = w[9:0];
        m_sym   = first ? (4'b0001 << w[11:10]) : 4'b0000;
        m_ready = (mq.size() < DEPTH);
    endtask

    // Drive one cycle of inputs, step the model, then compare after the edge.
    task automatic cycle(input logic r, input logic e, input logic v, input logic sf,
                         input logic [1:0] pn, input logic [9:0] dt);
        rst     = r;
        enable  = e;
        s_valid = v;
        s_sof   = sf;
        s_panel = pn;
        s_data  = dt;
        model_step(r, e, v, sf, pn, dt);
        @(negedge clk);
        cyc++;
        if (paam_data_valid) begin
            vcount++;
            vlog.push_back(cyc);
        end
        check("model", 64'({s_ready, paam_data_valid, paam_data, paam_symbol_start,
                            frame_cnt, drop_cnt, underrun_err}),
                       64'({m_ready, m_valid, m_data, m_sym,
                            m_frame, m_drop, m_underrun}));
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 10'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 10'd0);
    endtask

    task automatic send_words(input logic e, input int n, input logic sof_first,
                              input logic [1:0] pn, input logic [9:0] base);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, e, 1'b1, (i == 0) ? sof_first : 1'b0, pn, base + 10'(i));
        end
    endtask

    task automatic idle(input logic e, input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, e, 1'b0, 1'b0, 2'd0, 10'd0);
        end
    endtask

    initial begin
        // Directed frame: 8 words 0x001..0x008, panel 2, sof on the first.
        for (int i = 0; i < 12; i++) begin
            tbl[i].v    = (i < 8);
            tbl[i].sof  = (i == 0);
            tbl[i].data = (i < 8) ? 10'(i + 1) : 10'd0;
            tbl[i].ev   = (i >= 2 && i <= 9);
            tbl[i].ed   = (i < 2) ? 10'd0 : ((i <= 9) ? 10'(i - 1) : 10'd8);
            tbl[i].es   = (i == 2) ? 4'b0100 : 4'b0000;
            tbl[i].ef   = (i >= 9) ? 16'd1 : 16'd0;
        end

        rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_sof = 1'b0;
        s_panel = 2'd0; s_data = 10'd0;
        @(negedge clk);

        // Reset state
        do_reset();
        check("rst_ready",    64'(s_ready),           64'(1));
        check("rst_valid",    64'(paam_data_valid),   64'(0));
        check("rst_data",     64'(paam_data),         64'(0));
        check("rst_sym",      64'(paam_symbol_start), 64'(0));
        check("rst_counts",   64'({frame_cnt, drop_cnt, underrun_err}), 64'(0));

        // Vector table
        for (int i = 0; i < 12; i++) begin
            check($sformatf("tbl%0d_valid", i), 64'(paam_data_valid),   64'(tbl[i].ev));
            check($sformatf("tbl%0d_data", i),  64'(paam_data),         64'(tbl[i].ed));
            check($sformatf("tbl%0d_sym", i),   64'(paam_symbol_start), 64'(tbl[i].es));
            check($sformatf("tbl%0d_frame", i), 64'(frame_cnt),         64'(tbl[i].ef));
            check($sformatf("tbl%0d_ready", i), 64'(s_ready),           64'(1));
            cycle(1'b0, 1'b1, tbl[i].v, tbl[i].sof, 2'd2, tbl[i].data);
        end

        // Three stray words are dropped before a frame
        do_reset();
        vcount = 0;
        send_words(1'b1, 3, 1'b0, 2'd1, 10'h3A0);
        send_words(1'b1, FLEN, 1'b1, 2'd1, 10'h100);
        idle(1'b1, 12);
        check("drop3_cnt",   64'(drop_cnt),  64'(3));
        check("drop3_frame", 64'(frame_cnt), 64'(1));
        check("drop3_vcnt",  64'(vcount),    64'(FLEN));

        // Underrun: a 4-word fragment, then a complete frame
        do_reset();
        vcount = 0;
        send_words(1'b1, 4, 1'b1, 2'd0, 10'h050);
        idle(1'b1, 12);
        check("udr_vcnt",  64'(vcount),       64'(4));
        check("udr_flag",  64'(underrun_err), 64'(1));
        check("udr_frame", 64'(frame_cnt),    64'(0));
        send_words(1'b1, FLEN, 1'b1, 2'd3, 10'h060);
        idle(1'b1, 12);
        check("udr_next_frame", 64'(frame_cnt), 64'(1));
        check("udr_next_vcnt",  64'(vcount),    64'(4 + FLEN));

        // Fill to full with enable low, then release
        do_reset();
        vcount = 0;
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b0, 1'b1, (i == 0 || i == FLEN), 2'd3, 10'(i + 1));
        end
        check("full_ready", 64'(s_ready), 64'(0));
        check("full_vcnt",  64'(vcount),  64'(0));
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 10'h3FF);
        check("full_hold_ready", 64'(s_ready), 64'(0));
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 10'd0);
        check("ready_after_pop", 64'(s_ready), 64'(1));
        idle(1'b1, 30);
        check("full_frames", 64'(frame_cnt), 64'(2));
        check("full_vcnt2",  64'(vcount),    64'(2 * FLEN));

        // Reset in the middle of a frame (counters are non-zero beforehand)
        send_words(1'b1, 4, 1'b1, 2'd0, 10'h200);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 10'h204);
        check("mid_rst_valid",  64'(paam_data_valid),   64'(0));
        check("mid_rst_data",   64'(paam_data),         64'(0));
        check("mid_rst_sym",    64'(paam_symbol_start), 64'(0));
        check("mid_rst_ready",  64'(s_ready),           64'(1));
        check("mid_rst_counts", 64'({frame_cnt, drop_cnt, underrun_err}), 64'(0));
        vcount = 0;
        for (int i = 5; i < FLEN; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 10'h200 + 10'(i));
        end
        idle(1'b1, 6);
        check("mid_rst_no_out", 64'(vcount),   64'(0));
        check("mid_rst_drops",  64'(drop_cnt), 64'(FLEN - 5));

        // Back-to-back frames: exactly GLEN idle cycles between them
        do_reset();
        vlog.delete();
        send_words(1'b1, FLEN, 1'b1, 2'd1, 10'h010);
        send_words(1'b1, FLEN, 1'b1, 2'd3, 10'h020);
        idle(1'b1, 20);
        check("b2b_count", 64'(vlog.size()), 64'(2 * FLEN));
        if (vlog.size() > FLEN) begin
            check("b2b_gap", 64'(vlog[FLEN] - vlog[FLEN - 1]), 64'(GLEN + 1));
        end

        // drop_cnt saturates at 255
        do_reset();
        send_words(1'b0, 260, 1'b0, 2'd0, 10'h000);
        idle(1'b0, 3);
        check("drop_sat", 64'(drop_cnt), 64'(255));

        // Random traffic against the model
        do_reset();
        for (int blk = 0; blk < 6; blk++) begin
            for (int n = 0; n < 100; n++) begin
                logic r, e, v, sf;
                r  = ($urandom_range(0, 249) == 0);
                e  = ($urandom_range(0, 99) < ((blk % 3 == 0) ? 10 : 90));
                v  = ($urandom_range(0, 99) < ((blk < 3) ? 90 : 50));
                sf = ($urandom_range(0, 5) == 0);
                cycle(r, e, v, sf, 2'($urandom_range(0, 3)), 10'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/paam_data_tx.md
PAAM_DATA_TX -- requirements
Module: paam_data_tx

Interface
- REQ-001: FIFO_DEPTH, 16, buffer entries; power of two, minimum 4.
- REQ-002: FRAME_LEN, 8, words per frame; range 1..255.
- REQ-003: GAP_LEN, 2, idle cycles between frames; range 1..15.
- REQ-004: clk  in  1  single clock; all logic rising-edge.
- REQ-005: rst  in  1  synchronous, active-high reset.
- REQ-006: enable  in  1  permits new frames to start.
- REQ-007: s_data  in  10  payload word.
- REQ-008: s_sof  in  1  word is first of a frame.
- REQ-009: s_panel  in  2  target panel, sampled with s_sof word.
- REQ-010: s_valid  in  1  upstream word valid.
- REQ-011: s_ready  out  1  block can accept a word.
- REQ-012: paam_data  out  10  word to PAAM data bus.
- REQ-013: paam_symbol_start  out  4  one-hot, first word of frame.
- REQ-014: paam_data_valid  out  1  paam_data valid this cycle.
- REQ-015: frame_cnt  out  16  completed-frame counter.
- REQ-016: drop_cnt  out  8  words discarded while hunting for sof, saturating.
- REQ-017: underrun_err  out  1  sticky, frame aborted on empty FIFO.

Function
- REQ-018: Entries stored as {sof, panel, data}, 13 bits.
- REQ-019: Transfer occurs when s_valid and s_ready are both high.
- REQ-020: s_ready = (fill < FIFO_DEPTH), from a registered fill count.
- REQ-021: Write and read in the same cycle leave the fill count unchanged.
- REQ-022: Three states: IDLE, SEND, GAP.
- REQ-023: IDLE, head non-empty, head sof=0: discard the head (pop); drop_cnt increments, saturating at 255.
- REQ-024: IDLE, head sof=1, enable=1: go to SEND and pop the head as word 0 of the frame.
- REQ-025: IDLE, head sof=1, enable=0: hold the head (no pop, no drop).
- REQ-026: SEND pops one word per cycle for FRAME_LEN words total.
- REQ-027: Data outputs are registered; a word popped in cycle n appears on paam_data/paam_data_valid in cycle n+1.
- REQ-028: paam_symbol_start[panel] is high for exactly the word-0 output cycle; panel comes from word 0; all other bits are 0.
- REQ-029: An sof=1 word popped inside a frame (word index >= 1) is sent as plain data; it does not restart the frame.
- REQ-030: SEND with FIFO empty before FRAME_LEN words are sent:
  - abort the frame;
  - no output that cycle (valid=0);
  - set underrun_err;
  - frame_cnt unchanged;
  - go to IDLE.
- REQ-031: SEND, last word popped: frame_cnt increments (wraps 0xFFFF -> 0); go to GAP.
- REQ-032: GAP holds paam_data_valid=0 for GAP_LEN cycles, then returns to IDLE.
- REQ-033: enable deasserted mid-frame does not truncate the frame.
- REQ-034: Latency: an sof word written into an empty FIFO in IDLE at cycle n is output at cycle n+2.
- REQ-035: paam_data holds its last value while paam_data_valid=0.

Reset
- REQ-036: rst forces the following in the next cycle, overriding any in-flight transfer:
  - state=IDLE;
  - FIFO empty; s_ready=1;
  - paam_data=0, paam_symbol_start=0, paam_data_valid=0;
  - frame_cnt=0, drop_cnt=0, underrun_err=0.
- REQ-037: Reset mid-frame discards the partial frame; no further valid outputs are produced for it.

Verification
- REQ-038: FRAME_LEN=8, panel=2, 8 contiguous words 0x001..0x008 starting with sof=1 -> valid high for 8 cycles, first output 2 cycles after the first write, symbol_start=4'b0100 on word 0x001 only, frame_cnt=1.
- REQ-039: 3 words with sof=0, then a frame -> drop_cnt=3; frame output intact.
- REQ-040: sof word then 3 words, then s_valid low -> 4 valid outputs, underrun_err=1, frame_cnt=0; a following full frame is sent normally.
- REQ-041: Fill with enable=0, FIFO_DEPTH=16 -> s_ready low after 16 writes; no output; enable=1 -> frame starts; s_ready rises the cycle after the first pop.
- REQ-042: Two back-to-back frames with GAP_LEN=2 -> exactly 2 invalid cycles between the last word of frame 1 and the symbol_start of frame 2.
- REQ-043: rst asserted at word 4 of a frame -> all outputs 0 the next cycle, s_ready=1, counters 0.
